hub75_scan_ctrl: RTL and testbench

- Scan/timing controller directly downstream of the 3-byte RGB receive stage.
- Consumes its one-hot phase strobes (pwm / pix+row+alrst / lat) and drives the feedback `pwm_value`, the HUB75 row address, LAT and OE.
- Also drives the AL422 read-reset and a shift-enable that gates led_clk and FIFO /RE outside the shift window.
- One frame = ROWS lines of PIX_PER_ROW pixels; one full frame is replayed per PWM step.

---
 rtl/hub75_scan_ctrl_pkg.sv | 26 ++
 rtl/hub75_wrap_counter.sv | 28 ++
 rtl/hub75_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hub75_scan_ctrl_pkg.sv
// Shared types and constants for the HUB75 scan controller.
package hub75_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_START,
    ST_SHIFT,
    ST_LATCH,
    ST_ROWSET,
    ST_ARM
  } scan_state_e;

  localparam int unsigned DEF_PIX_PER_ROW = 64;
  localparam int unsigned DEF_ROWS        = 16;
  localparam int unsigned DEF_PWM_W       = 8;
  localparam int unsigned DEF_PWM_MAX     = 254;

  localparam int unsigned PH_PWM = 0;
  localparam int unsigned PH_PIX = 1;
  localparam int unsigned PH_LAT = 2;

  // Counter width for n states, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_wrap_counter.sv
// Modulo counter: counts 0..MAX on en_i and wraps; tc_o flags MAX.
module hub75_wrap_counter #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == W'(MAX));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan/timing controller: sequences shift, latch, row update and
// PWM step from the upstream one-hot phase strobes.
module hub75_scan_ctrl
  import hub75_scan_ctrl_pkg::*;
#(
  parameter  int unsigned PIX_PER_ROW = DEF_PIX_PER_ROW,
  parameter  int unsigned ROWS        = DEF_ROWS,
  parameter  int unsigned PWM_W       = DEF_PWM_W,
  parameter  int unsigned PWM_MAX     = DEF_PWM_MAX,
  localparam int unsigned ROW_W       = cnt_width(ROWS)
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_enable,
  input  logic             pix_cntr_strobe,
  input  logic             row_cntr_strobe,
  input  logic             pwm_cntr_strobe,
  input  logic             lat_strobe,
  input  logic             alrst_strobe,
  output logic [PWM_W-1:0] pwm_value,
  output logic [ROW_W-1:0] out_row,
  output logic             out_lat,
  output logic             out_oe_n,
  output logic             out_shift_en,
  output logic             out_fifo_rrst_n,
  output logic             out_frame_done
);

  localparam int unsigned PIX_W = cnt_width(PIX_PER_ROW);

  scan_state_e      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             lat_q, lat_d;
  logic             oe_n_q, oe_n_d;
  logic             shift_en_q, shift_en_d;
  logic             rrst_n_q, rrst_n_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_end_q, frame_end_d;
  logic [1:0]       hold_q, hold_d;

  logic             pix_en, row_en, pwm_en;
  logic [PIX_W-1:0] pix_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             pix_tc, row_tc, pwm_tc;
  logic             unused_sig;

  assign unused_sig = ^{pix_cnt, pwm_tc, alrst_strobe};

  hub75_wrap_counter #(.W(PIX_W), .MAX(PIX_PER_ROW - 1)) u_pix_cnt (
    .clk_i(in_clk), .rst_i(in_rst), .en_i(pix_en), .cnt_o(pix_cnt), .tc_o(pix_tc)
  );

  hub75_wrap_counter #(.W(ROW_W), .MAX(ROWS - 1)) u_row_cnt (
    .clk_i(in_clk), .rst_i(in_rst), .en_i(row_en), .cnt_o(row_cnt), .tc_o(row_tc)
  );

  hub75_wrap_counter #(.W(PWM_W), .MAX(PWM_MAX)) u_pwm_cnt (
    .clk_i(in_clk), .rst_i(in_rst), .en_i(pwm_en), .cnt_o(pwm_value), .tc_o(pwm_tc)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    lat_d        = 1'b0;
    oe_n_d       = oe_n_q;
    shift_en_d   = shift_en_q;
    rrst_n_d     = rrst_n_q;
    frame_done_d = 1'b0;
    frame_end_d  = frame_end_q;
    hold_d       = hold_q;
    pix_en       = 1'b0;
    row_en       = 1'b0;
    pwm_en       = 1'b0;

    // The end-of-frame FIFO reset is timed by clocks, not by the ARM strobe,
    // so RRST stays low for a full strobe round (3 clocks).
    if (!rrst_n_q && hold_q != 2'd0) hold_d = hold_q - 2'd1;
    if (!rrst_n_q && hold_q == 2'd0 && state_q != ST_START) rrst_n_d = 1'b1;

    unique case (state_q)
      ST_START: begin
        rrst_n_d = 1'b0;
        if (pwm_cntr_strobe) begin
          rrst_n_d   = 1'b1;
          shift_en_d = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        oe_n_d = ~in_enable;
        if (pix_cntr_strobe) begin
          pix_en = 1'b1;
          if (pix_tc) begin
            shift_en_d = 1'b0;
            oe_n_d     = 1'b1;
            state_d    = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (lat_strobe) begin
          lat_d   = 1'b1;
          state_d = ST_ROWSET;
        end
      end
      ST_ROWSET: begin
        if (row_cntr_strobe) begin
          row_en = 1'b1;
          row_d  = row_cnt;
          if (row_tc) begin
            rrst_n_d     = 1'b0;
            hold_d       = 2'd2;
            frame_done_d = 1'b1;
            frame_end_d  = 1'b1;
          end
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (pwm_cntr_strobe) begin
          shift_en_d = 1'b1;
          oe_n_d     = ~in_enable;
          state_d    = ST_SHIFT;
          if (frame_end_q) begin
            pwm_en      = 1'b1;
            frame_end_d = 1'b0;
          end
        end
      end
      default: state_d = ST_START;
    endcase

    if (!in_enable) oe_n_d = 1'b1;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= ST_START;
      row_q        <= '0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      shift_en_q   <= 1'b0;
      rrst_n_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_end_q  <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      lat_q        <= lat_d;
      oe_n_q       <= oe_n_d;
      shift_en_q   <= shift_en_d;
      rrst_n_q     <= rrst_n_d;
      frame_done_q <= frame_done_d;
      frame_end_q  <= frame_end_d;
      hold_q       <= hold_d;
    end
  end

  assign out_row         = row_q;
  assign out_lat         = lat_q;
  assign out_oe_n        = oe_n_q;
  assign out_shift_en    = shift_en_q;
  assign out_fifo_rrst_n = rrst_n_q;
  assign out_frame_done  = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl with a 3-phase strobe generator.
module tb_hub75_scan_ctrl;
  import hub75_scan_ctrl_pkg::*;

  localparam int unsigned S_PWM = 0;
  localparam int unsigned S_PIX = 1;
  localparam int unsigned S_LAT = 2;
  localparam int unsigned S_ROW = 3;
  localparam int unsigned WAIT_LIMIT = 20;

  logic       clk, rst, en;
  logic       pix_s, row_s, pwm_s, lat_s, alrst_s;
  logic [7:0] pwm_value;
  logic [0:0] out_row;
  logic       out_lat, out_oe_n, out_shift_en, out_fifo_rrst_n, out_frame_done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned fd_cnt = 0;
  int unsigned ph = 0;

  hub75_scan_ctrl #(.PIX_PER_ROW(4), .ROWS(2), .PWM_W(8), .PWM_MAX(2)) dut (
    .in_clk(clk), .in_rst(rst), .in_enable(en),
    .pix_cntr_strobe(pix_s), .row_cntr_strobe(row_s), .pwm_cntr_strobe(pwm_s),
    .lat_strobe(lat_s), .alrst_strobe(alrst_s),
    .pwm_value(pwm_value), .out_row(out_row), .out_lat(out_lat),
    .out_oe_n(out_oe_n), .out_shift_en(out_shift_en),
    .out_fifo_rrst_n(out_fifo_rrst_n), .out_frame_done(out_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    pix_s = 0; row_s = 0; pwm_s = 0; lat_s = 0; alrst_s = 0;
    forever begin
      @(posedge clk);
      #1;
      pwm_s   = (ph == PH_PWM);
      pix_s   = (ph == PH_PIX);
      row_s   = (ph == PH_PIX);
      alrst_s = (ph == PH_PIX);
      lat_s   = (ph == PH_LAT);
      ph = (ph == 2) ? 0 : ph + 1;
    end
  end

  always @(negedge clk) if (out_frame_done) fd_cnt <= fd_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic strobe_sel(input int unsigned w);
    case (w)
      S_PWM:   return pwm_s;
      S_PIX:   return pix_s;
      S_LAT:   return lat_s;
      default: return row_s;
    endcase
  endfunction

  // Returns at the falling edge after the clock that consumed the strobe.
  task automatic wait_strobe(input int unsigned w);
    int unsigned n = 0;
    while (!strobe_sel(w) && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("strobe_wait_timeout", 32'(n >= WAIT_LIMIT), 0);
    @(negedge clk);
  endtask

  task automatic run_line();
    repeat (4) wait_strobe(S_PIX);
    wait_strobe(S_LAT);
    wait_strobe(S_ROW);
    wait_strobe(S_PWM);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_pwm"},    32'(pwm_value),       0);
    check({pfx, "_row"},    32'(out_row),         0);
    check({pfx, "_lat"},    32'(out_lat),         0);
    check({pfx, "_oe_n"},   32'(out_oe_n),        1);
    check({pfx, "_shift"},  32'(out_shift_en),    0);
    check({pfx, "_rrst_n"}, 32'(out_fifo_rrst_n), 0);
    check({pfx, "_fdone"},  32'(out_frame_done),  0);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    repeat (4) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;

    // Frame 1, line 1
    wait_strobe(S_PWM);
    check("start_rrst_n", 32'(out_fifo_rrst_n), 1);
    check("start_shift",  32'(out_shift_en),    1);
    check("start_pwm",    32'(pwm_value),       0);
    check("start_row",    32'(out_row),         0);
    repeat (3) wait_strobe(S_PIX);
    check("pix3_shift", 32'(out_shift_en), 1);
    check("pix3_oe_n",  32'(out_oe_n),     0);
    wait_strobe(S_PIX);
    check("pix4_shift", 32'(out_shift_en), 0);
    check("pix4_oe_n",  32'(out_oe_n),     1);
    wait_strobe(S_LAT);
    check("lat_high", 32'(out_lat), 1);
    @(negedge clk);
    check("lat_low", 32'(out_lat), 0);
    wait_strobe(S_ROW);
    check("l1_row",   32'(out_row),        0);
    check("l1_fdone", 32'(out_frame_done), 0);
    wait_strobe(S_PWM);
    check("arm_shift", 32'(out_shift_en), 1);
    check("arm_oe_n",  32'(out_oe_n),     0);
    check("arm_pwm",   32'(pwm_value),    0);

    // Frame 1, line 2: end of frame
    repeat (4) wait_strobe(S_PIX);
    wait_strobe(S_LAT);
    wait_strobe(S_ROW);
    check("l2_row",    32'(out_row),         1);
    check("l2_rrst0",  32'(out_fifo_rrst_n), 0);
    check("l2_fdone1", 32'(out_frame_done),  1);
    @(negedge clk);
    check("l2_fdone0", 32'(out_frame_done),  0);
    check("l2_rrst1",  32'(out_fifo_rrst_n), 0);
    @(negedge clk);
    check("l2_rrst2",  32'(out_fifo_rrst_n), 0);
    check("f2_pwm",    32'(pwm_value),       1);
    check("f2_shift",  32'(out_shift_en),    1);
    @(negedge clk);
    check("l2_rrst_up", 32'(out_fifo_rrst_n), 1);

    // Frame 2: one pix of line 1 was consumed above
    repeat (3) wait_strobe(S_PIX);
    wait_strobe(S_LAT);
    wait_strobe(S_ROW);
    check("f2l1_row", 32'(out_row), 0);
    wait_strobe(S_PWM);
    run_line();
    check("f3_pwm", 32'(pwm_value), 2);

    // Frame 3
    run_line();
    check("f3_pwm_mid", 32'(pwm_value), 2);
    run_line();
    check("f4_pwm_wrap", 32'(pwm_value), 0);
    check("fdone_count", 32'(fd_cnt), 3);

    // Frame 4, line 1: display enable toggled mid-shift
    wait_strobe(S_PIX);
    en = 1'b0;
    @(negedge clk);
    check("dis_oe_n", 32'(out_oe_n), 1);
    en = 1'b1;
    @(negedge clk);
    check("ena_oe_n", 32'(out_oe_n), 0);
    repeat (3) wait_strobe(S_PIX);
    check("en_pix4_shift", 32'(out_shift_en), 0);
    wait_strobe(S_LAT);
    check("en_lat", 32'(out_lat), 1);
    wait_strobe(S_ROW);
    check("en_row", 32'(out_row), 0);
    wait_strobe(S_PWM);
    check("en_pwm", 32'(pwm_value), 0);
    run_line();
    check("f5_pwm", 32'(pwm_value), 1);
    check("f5_row", 32'(out_row),   1);

    // Frame 5, line 1: asynchronous reset at pix_cnt == 2
    repeat (2) wait_strobe(S_PIX);
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    wait_strobe(S_PWM);
    check("rec_shift",  32'(out_shift_en),    1);
    check("rec_rrst_n", 32'(out_fifo_rrst_n), 1);
    repeat (3) wait_strobe(S_PIX);
    check("rec_pix3_shift", 32'(out_shift_en), 1);
    wait_strobe(S_PIX);
    check("rec_pix4_shift", 32'(out_shift_en), 0);
    wait_strobe(S_LAT);
    check("rec_lat", 32'(out_lat), 1);
    wait_strobe(S_ROW);
    check("rec_row", 32'(out_row),   0);
    check("rec_pwm", 32'(pwm_value), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
